// File: rtl/led_afterglow_driver_pkg.sv
// Shared types and defaults for the LED afterglow driver.
//
// blink_state_t : states of the blink-code override FSM
// GAP_PERIODS_DEFAULT : blink periods of dark gap after a code
package led_afterglow_driver_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PULSE_ON  = 2'd1,
    PULSE_OFF = 2'd2,
    GAP       = 2'd3
  } blink_state_t;

  localparam int GAP_PERIODS_DEFAULT = 4;

endpackage

// File: rtl/led_afterglow_driver_pwm_channel.sv
// One LED channel: intensity level register with afterglow decay, plus the
// PWM compare against the shared free-running counter.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high
//   pattern_bit  eye pattern level for this LED
//   brightness   level loaded while pattern_bit is high
//   fade_en      1 = halve level on each fade tick once the bit drops,
//                0 = go dark immediately
//   fade_tick    one-clock decay strobe from the shared prescaler
//   pwm_cnt      shared PWM phase counter
//   pwm_on       combinational PWM drive for this LED
module led_pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pattern_bit,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                fade_en,
  input  logic                fade_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pwm_on
);

  logic [PWM_BITS-1:0] level;

  // A lit bit reloads every clock, so a fade tick coinciding with the load
  // never halves a freshly lit LED.
  always_ff @(posedge clock) begin
    if (reset) begin
      level <= '0;
    end else if (pattern_bit) begin
      level <= brightness;
    end else if (!fade_en) begin
      level <= '0;
    end else if (fade_tick) begin
      level <= level >> 1;
    end
  end

  // Strict compare: level 0 is never on, full scale misses one phase.
  assign pwm_on = (level > pwm_cnt);

endmodule

// File: rtl/led_afterglow_driver.sv
// Front-panel LED driver: per-LED afterglow PWM dimming of the cylon eye
// pattern, with a valid/ready blink-code channel that temporarily overrides
// the whole panel with N full-on flashes followed by a dark gap.
//
// Ports
//   clock       system clock, the only clock
//   reset       synchronous, active-high
//   pattern     eye pattern, one level per LED
//   brightness  intensity loaded into lit LEDs
//   fade_en     1 = exponential afterglow, 0 = dark as soon as a bit drops
//   code_valid  blink-code request (held by upstream until accepted)
//   code_num    number of flashes, 0 is accepted and discarded
//   code_ready  registered, high only while the blink FSM is idle
//   leds        registered LED drive, 1 = on
//
// Blink FSM
//   state     | meaning
//   IDLE      | panel shows PWM display, code_ready high
//   PULSE_ON  | all LEDs on for one blink period
//   PULSE_OFF | all LEDs off for one blink period
//   GAP       | all LEDs off for GAP_PERIODS blink periods, then IDLE
module led_afterglow_driver
  import led_afterglow_driver_pkg::*;
#(
  parameter int NLED        = 4,
  parameter int PWM_BITS    = 8,
  parameter int FADE_PRE    = 16,
  parameter int BLINK_PRE   = 22,
  parameter int GAP_PERIODS = GAP_PERIODS_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NLED-1:0]     pattern,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                fade_en,
  input  logic                code_valid,
  input  logic [3:0]          code_num,
  output logic                code_ready,
  output logic [NLED-1:0]     leds
);

  // Duration counter must span the longest state (the gap).
  localparam int DUR_W = BLINK_PRE + $clog2(GAP_PERIODS) + 1;
  localparam logic [DUR_W-1:0] PULSE_LAST =
    DUR_W'((64'd1 << BLINK_PRE) - 64'd1);
  localparam logic [DUR_W-1:0] GAP_LAST =
    DUR_W'((64'(GAP_PERIODS) << BLINK_PRE) - 64'd1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [FADE_PRE-1:0] fade_pre;
  logic                fade_tick;
  logic [NLED-1:0]     pwm_on;

  blink_state_t        state;
  blink_state_t        state_next;
  logic [DUR_W-1:0]    dur_cnt;
  logic [3:0]          flash_cnt;
  logic [3:0]          flash_cnt_next;
  logic                xfer;
  logic                ready_next;
  logic [NLED-1:0]     override;
  logic [NLED-1:0]     leds_next;

  assign fade_tick = &fade_pre;

  // ---------------------------------------------------------------------
  // LED channels
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < NLED; g++) begin : g_chan
    led_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clock       (clock),
      .reset       (reset),
      .pattern_bit (pattern[g]),
      .brightness  (brightness),
      .fade_en     (fade_en),
      .fade_tick   (fade_tick),
      .pwm_cnt     (pwm_cnt),
      .pwm_on      (pwm_on[g])
    );
  end

  // ---------------------------------------------------------------------
  // Blink FSM next state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_next     = state;
    flash_cnt_next = flash_cnt;
    override       = '0;
    xfer           = code_valid && code_ready && (state == IDLE);

    case (state)
      IDLE: begin
        if (xfer && (code_num != 4'd0)) begin
          state_next     = PULSE_ON;
          flash_cnt_next = code_num;
        end
      end
      PULSE_ON: begin
        override = '1;
        if (dur_cnt == PULSE_LAST) begin
          state_next     = PULSE_OFF;
          flash_cnt_next = flash_cnt - 4'd1;
        end
      end
      PULSE_OFF: begin
        if (dur_cnt == PULSE_LAST) begin
          state_next = (flash_cnt == 4'd0) ? GAP : PULSE_ON;
        end
      end
      GAP: begin
        if (dur_cnt == GAP_LAST) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A zero-length code still takes the handshake, so ready dips for one
    // clock even though the FSM never leaves IDLE.
    ready_next = (state_next == IDLE) && !xfer;
    leds_next  = (state == IDLE) ? pwm_on : override;
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      pwm_cnt    <= '0;
      fade_pre   <= '0;
      state      <= IDLE;
      dur_cnt    <= '0;
      flash_cnt  <= '0;
      code_ready <= 1'b0;
      leds       <= '0;
    end else begin
      pwm_cnt    <= pwm_cnt + PWM_BITS'(1);
      fade_pre   <= fade_pre + FADE_PRE'(1);
      state      <= state_next;
      flash_cnt  <= flash_cnt_next;
      code_ready <= ready_next;
      leds       <= leds_next;
      // Restart timing on every state entry; parked at zero while idle.
      if ((state_next != state) || (state == IDLE)) begin
        dur_cnt <= '0;
      end else begin
        dur_cnt <= dur_cnt + DUR_W'(1);
      end
    end
  end

endmodule
